// File: rtl/multi_port_reg_file_if.sv
// Bus bundle for multi_port_reg_file: read/write port vectors, clear control and status.
// fsm_state mirrors the clear-engine state (0 = IDLE, 1 = CLEAR) for observation.
interface multi_port_reg_file_if #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_READ  = 4,
  parameter int NUM_WRITE = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_READ*ADDR_W-1:0]  readAddr;
  logic [NUM_READ*DATA_W-1:0]  dataOut;
  logic [NUM_WRITE*ADDR_W-1:0] writeAddr;
  logic [NUM_WRITE-1:0]        writeEnable;
  logic [NUM_WRITE*DATA_W-1:0] dataIn;
  logic                        clearReq;
  logic                        busy;
  logic                        clearDone;
  logic                        writeConflict;
  logic                        fsm_state;

  modport master (
    output readAddr, writeAddr, writeEnable, dataIn, clearReq,
    input  dataOut, busy, clearDone, writeConflict, fsm_state
  );

  modport slave (
    input  readAddr, writeAddr, writeEnable, dataIn, clearReq,
    output dataOut, busy, clearDone, writeConflict, fsm_state
  );
endinterface

// File: rtl/multi_port_reg_file.sv
// N-read / M-write register file with registered reads, fixed-priority write merge and a
// one-entry-per-cycle clear engine. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module multi_port_reg_file #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_READ  = 4,
  parameter int NUM_WRITE = 4
) (
  input logic                clk,
  input logic                rstN,
  multi_port_reg_file_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              clr_active, clr_last, wr_allow;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q [NUM_READ];
  logic [DATA_W-1:0] rd_next [NUM_READ];
  logic              conflict_q, done_q;

  logic [ADDR_W-1:0] wa [NUM_WRITE];
  logic [DATA_W-1:0] wd [NUM_WRITE];
  logic [ADDR_W-1:0] ra [NUM_READ];

  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_data [DEPTH];
  logic              conflict;

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
    assign wa[w] = bus.writeAddr[w*ADDR_W +: ADDR_W];
    assign wd[w] = bus.dataIn[w*DATA_W +: DATA_W];
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    assign ra[r] = bus.readAddr[r*ADDR_W +: ADDR_W];
    assign bus.dataOut[r*DATA_W +: DATA_W] = rd_q[r];
  end

  // State register and clear counter
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt;
    case (state_q)
      IDLE: begin
        if (bus.clearReq) begin
          state_d   = CLEAR;
          clr_cnt_d = ADDR_W'(1);
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_ENTRY) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    clr_active = 1'b0;
    clr_last   = 1'b0;
    wr_allow   = 1'b0;
    case (state_q)
      IDLE:    wr_allow = 1'b1;
      CLEAR: begin
        clr_active = 1'b1;
        clr_last   = (clr_cnt == LAST_ENTRY);
      end
      default: wr_allow = 1'b0;
    endcase
  end

  // Highest-numbered port is applied first so the lowest-numbered port overrides it.
  always_comb begin
    wr_hit   = '0;
    conflict = 1'b0;
    for (int e = 0; e < DEPTH; e++) wr_data[e] = '0;
    for (int w = NUM_WRITE - 1; w >= 0; w--) begin
      if (wr_allow && bus.writeEnable[w] && (wa[w] != '0)) begin
        wr_hit[wa[w]]  = 1'b1;
        wr_data[wa[w]] = wd[w];
      end
    end
    for (int i = 0; i < NUM_WRITE; i++) begin
      for (int j = i + 1; j < NUM_WRITE; j++) begin
        if (wr_allow && bus.writeEnable[i] && bus.writeEnable[j] &&
            (wa[i] == wa[j]) && (wa[i] != '0)) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Entry 0 is only ever reset, so it stays zero.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 1; e < DEPTH; e++) begin
        if (clr_active && (clr_cnt == ADDR_W'(e))) begin
          mem[e] <= '0;
        end else if (wr_hit[e]) begin
          mem[e] <= wr_data[e];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rd_next[r] = '0;
      if (ra[r] != '0) begin
        rd_next[r] = mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
        // wr_hit is only ever set in IDLE, so the clear sweep never forwards.
        if (wr_hit[ra[r]]) rd_next[r] = wr_data[ra[r]];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int r = 0; r < NUM_READ; r++) rd_q[r] <= '0;
      conflict_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_READ; r++) rd_q[r] <= rd_next[r];
      conflict_q <= conflict;
      done_q     <= clr_last;
    end
  end

  assign bus.busy          = clr_active;
  assign bus.clearDone     = done_q;
  assign bus.writeConflict = conflict_q;
  assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench for multi_port_reg_file: read expectations queue into a scoreboard that a
// separate monitor drains when the registered read data appears.
module tb_multi_port_reg_file;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 32;
  localparam int NUM_READ  = 4;
  localparam int NUM_WRITE = 4;
  localparam int ADDR_W    = 5;
  localparam int RW        = NUM_READ * DATA_W;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h42;
`else
  localparam logic [31:0] BYP_EXP = 32'h7;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  multi_port_reg_file_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_READ(NUM_READ),
                           .NUM_WRITE(NUM_WRITE)) bus ();

  multi_port_reg_file #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_READ(NUM_READ),
                        .NUM_WRITE(NUM_WRITE)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  logic [RW-1:0] exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rd_issue = 1'b0;
  logic rd_v     = 1'b0;

  always @(posedge clk) rd_v <= rd_issue;

  always @(negedge clk) begin
    if (rd_v) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL read_data: got %h with no expectation queued", bus.dataOut);
      end else begin
        logic [RW-1:0] exp;
        exp = exp_q.pop_front();
        if (bus.dataOut !== exp) begin
          n_err++;
          $display("FAIL read_data: got %h want %h", bus.dataOut, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic clr_in();
    bus.writeEnable = '0;
    bus.clearReq    = 1'b0;
    rd_issue        = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    clr_in();
  endtask

  task automatic wr(input int w, input int a, input logic [31:0] d);
    bus.writeEnable[w]                 = 1'b1;
    bus.writeAddr[w*ADDR_W +: ADDR_W]  = a[ADDR_W-1:0];
    bus.dataIn[w*DATA_W +: DATA_W]     = d;
  endtask

  task automatic rd(input int r, input int a);
    bus.readAddr[r*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
  endtask

  task automatic expect_rd(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    exp_q.push_back({e3, e2, e1, e0});
    rd_issue = 1'b1;
  endtask

  task automatic read4(input int a0, input int a1, input int a2, input int a3,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    rd(0, a0); rd(1, a1); rd(2, a2); rd(3, a3);
    expect_rd(e0, e1, e2, e3);
    tick();
  endtask

  int n_busy;
  int n_done;

  initial begin
    bus.readAddr  = '0;
    bus.writeAddr = '0;
    bus.dataIn    = '0;
    clr_in();
    repeat (2) @(negedge clk);
    chk("reset_busy", RW'(bus.busy), '0);
    chk("reset_done", RW'(bus.clearDone), '0);
    chk("reset_conflict", RW'(bus.writeConflict), '0);
    chk("reset_dataout", bus.dataOut, '0);
    rstN = 1'b1;
    tick();

    // Every address on every port reads zero after reset
    for (int a = 0; a < DEPTH; a++)
      read4(a, (a + 1) % DEPTH, (a + 2) % DEPTH, (a + 3) % DEPTH, 0, 0, 0, 0);
    chk("idle_busy", RW'(bus.busy), '0);

    // Four distinct writes in one cycle
    wr(0, 5, 32'hA5); wr(1, 6, 32'hB6); wr(2, 7, 32'hC7); wr(3, 8, 32'hD8);
    tick();
    chk("distinct_conflict", RW'(bus.writeConflict), '0);
    read4(5, 6, 7, 8, 32'hA5, 32'hB6, 32'hC7, 32'hD8);

    // Ports 1 and 3 collide on reg 9; port 1 wins
    wr(1, 9, 32'h111); wr(3, 9, 32'h333);
    tick();
    chk("collide_conflict", RW'(bus.writeConflict), RW'(1));
    read4(9, 0, 0, 0, 32'h111, 0, 0, 0);
    chk("collide_conflict_drop", RW'(bus.writeConflict), '0);

    // Ports 0 and 2 collide on reg 10 while port 1 writes reg 11
    wr(0, 10, 32'hAAA); wr(1, 11, 32'hBBB); wr(2, 10, 32'hCCC);
    tick();
    chk("prio_conflict", RW'(bus.writeConflict), RW'(1));
    read4(10, 11, 5, 9, 32'hAAA, 32'hBBB, 32'hA5, 32'h111);

    // Writes to reg 0 are discarded and never conflict
    wr(0, 0, 32'hFFFF_FFFF); wr(2, 0, 32'h1234_5678);
    tick();
    chk("zero_conflict", RW'(bus.writeConflict), '0);
    read4(0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write/read of reg 4
    wr(0, 4, 32'h7);
    tick();
    wr(1, 4, 32'h42);
    rd(0, 4); rd(1, 5); rd(2, 0); rd(3, 4);
    expect_rd(BYP_EXP, 32'hA5, 0, BYP_EXP);
    tick();
    read4(4, 4, 0, 6, 32'h42, 32'h42, 0, 32'hB6);

    // Fill regs 1..31 with their index
    for (int i = 1; i < DEPTH; i += 4) begin
      for (int w = 0; w < NUM_WRITE; w++)
        if (i + w < DEPTH) wr(w, i + w, 32'(i + w));
      tick();
    end
    read4(1, 2, 30, 31, 32'd1, 32'd2, 32'd30, 32'd31);

    // Clear request alongside a write: the write commits, then the sweep runs
    bus.clearReq = 1'b1;
    wr(0, 3, 32'h99);
    tick();
    n_busy = 0;
    n_done = 0;
    while (bus.busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      n_done += int'(bus.clearDone);
      if (n_busy == 1) begin
        rd(0, 3); rd(1, 20); rd(2, 1); rd(3, 0);
        expect_rd(32'h99, 32'd20, 32'd1, 0);
        wr(0, 20, 32'hDEAD); wr(1, 25, 32'h1); wr(2, 25, 32'h2);
      end
      if (n_busy == 2) chk("clear_conflict", RW'(bus.writeConflict), '0);
      if (n_busy == 10) bus.clearReq = 1'b1;
      tick();
    end
    chk("clear_busy_cycles", RW'(n_busy), RW'(31));
    chk("clear_done_early", RW'(n_done), '0);
    chk("clear_done_pulse", RW'(bus.clearDone), RW'(1));
    chk("clear_busy_end", RW'(bus.busy), '0);
    tick();
    chk("clear_done_once", RW'(bus.clearDone), '0);
    chk("clear_busy_stays_low", RW'(bus.busy), '0);
    for (int a = 0; a < DEPTH; a += 4) read4(a, a + 1, a + 2, a + 3, 0, 0, 0, 0);

    // Reset asserted in the middle of a clear
    wr(0, 7, 32'h77); wr(1, 31, 32'h31ABC);
    tick();
    read4(7, 31, 0, 0, 32'h77, 32'h31ABC, 0, 0);
    bus.clearReq = 1'b1;
    tick();
    repeat (5) tick();
    chk("midclear_busy", RW'(bus.busy), RW'(1));
    #2 rstN = 1'b0;
    #1;
    chk("midreset_busy", RW'(bus.busy), '0);
    chk("midreset_done", RW'(bus.clearDone), '0);
    chk("midreset_dataout", bus.dataOut, '0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    read4(7, 31, 5, 4, 0, 0, 0, 0);
    chk("postreset_busy", RW'(bus.busy), '0);
    chk("postreset_done", RW'(bus.clearDone), '0);
    repeat (3) tick();
    chk("queue_drained", RW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
